// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers with byte-strobe writes.
// Optional macro AXIL_PROT_CHECK_EN rejects unprivileged (prot[0]=0) accesses with SLVERR.
module axi4lite_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_LSB    = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(NUM_REGS);
    localparam int UPPER_LSB  = IDX_LSB + IDX_W;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> UPPER_LSB) != '0;
    endfunction

    wr_state_t               wr_state_q, wr_state_d;
    logic                    ready_en_q, ready_en_d;
    logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
    logic                    aw_err_q, aw_err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   reg_file_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   reg_file_d [NUM_REGS];

    logic                    aw_hs, w_hs, ar_hs;
    logic                    aw_access_err, ar_access_err;
    logic                    commit;
    logic [IDX_W-1:0]        commit_idx;
    logic                    commit_err;
    logic [DATA_WIDTH-1:0]   commit_data;
    logic [STRB_WIDTH-1:0]   commit_strb;

`ifdef AXIL_PROT_CHECK_EN
    assign aw_access_err = addr_out_of_range(awaddr) || !awprot[0];
    assign ar_access_err = addr_out_of_range(araddr) || !arprot[0];
`else
    logic unused_prot;
    assign aw_access_err = addr_out_of_range(awaddr);
    assign ar_access_err = addr_out_of_range(araddr);
    assign unused_prot   = ^{awprot, arprot};
`endif

    // ready_en_q keeps every ready low until the first edge after reset release
    assign awready = ready_en_q && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_W);
    assign wready  = ready_en_q && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_AW);
    assign arready = ready_en_q && !rvalid_q;
    assign bvalid  = (wr_state_q == W_RESP);
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign ready_en_d = 1'b1;

    always_comb begin
        wr_state_d  = wr_state_q;
        aw_idx_d    = aw_idx_q;
        aw_err_d    = aw_err_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        commit      = 1'b0;
        commit_idx  = (wr_state_q == W_HAVE_AW) ? aw_idx_q : awaddr[IDX_LSB +: IDX_W];
        commit_err  = (wr_state_q == W_HAVE_AW) ? aw_err_q : aw_access_err;
        commit_data = (wr_state_q == W_HAVE_W) ? wdata_q : wdata;
        commit_strb = (wr_state_q == W_HAVE_W) ? wstrb_q : wstrb;

        if (aw_hs) begin
            aw_idx_d = awaddr[IDX_LSB +: IDX_W];
            aw_err_d = aw_access_err;
        end
        if (w_hs) begin
            wdata_d = wdata;
            wstrb_d = wstrb;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_d = W_RESP;
                    commit     = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    wr_state_d = W_RESP;
                    commit     = 1'b1;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    wr_state_d = W_RESP;
                    commit     = 1'b1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        if (commit) begin
            bresp_d = commit_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_comb begin
        reg_file_d = reg_file_q;
        if (commit && !commit_err) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (commit_strb[b]) begin
                    reg_file_d[commit_idx][b*8 +: 8] = commit_data[b*8 +: 8];
                end
            end
        end
    end

    // Read samples reg_file_q, so a same-cycle write commit returns the old value
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (ar_access_err) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = reg_file_q[araddr[IDX_LSB +: IDX_W]];
                rresp_d = RESP_OKAY;
            end
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            ready_en_q <= 1'b0;
            aw_idx_q   <= '0;
            aw_err_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            ready_en_q <= ready_en_d;
            aw_idx_q   <= aw_idx_d;
            aw_err_q   <= aw_err_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                reg_file_q[gi] <= '0;
            end else begin
                reg_file_q[gi] <= reg_file_d[gi];
            end
        end
        assign regs_q[gi*DATA_WIDTH +: DATA_WIDTH] = reg_file_q[gi];
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Bench for axi4lite_reg_slave: directed AXI4-Lite transactions, a behavioural
// register-map model compared every cycle, and literal expectations per scenario.
`timescale 1ns/1ps
module tb_axi4lite_reg_slave;

    localparam int NR = 16;

`ifdef AXIL_PROT_CHECK_EN
    localparam logic [1:0]  UNPRIV_RESP = 2'b10;
    localparam logic [31:0] UNPRIV_REG5 = 32'h0000_0000;
    localparam logic [31:0] UNPRIV_RD   = 32'h0000_0000;
`else
    localparam logic [1:0]  UNPRIV_RESP = 2'b00;
    localparam logic [31:0] UNPRIV_REG5 = 32'h7777_7777;
    localparam logic [31:0] UNPRIV_RD   = 32'h7777_7777;
`endif

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [31:0]   awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [31:0]   araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [NR*32-1:0] regs_q;

    always #5 aclk = ~aclk;

    axi4lite_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(NR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_q(regs_q)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem [NR];
    bit          alive, have_aw, have_w, b_pend, r_pend;
    logic [31:0] m_aw_addr, m_w_data, m_r_data;
    logic [2:0]  m_aw_prot;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_b_resp, m_r_resp;

    // A 16 x 4-byte map occupies byte addresses 0..63; anything above errors.
    function automatic bit m_err(input logic [31:0] addr, input logic [2:0] prot);
        bit e;
        e = (addr >= 32'd64);
`ifdef AXIL_PROT_CHECK_EN
        if (!prot[0]) e = 1'b1;
`endif
        return e;
    endfunction

    always @(negedge aclk) begin
        bit exp_awr, exp_wr, exp_arr, aw_h, w_h, ar_h;
        int idx;
        if (!aresetn) begin
            check("rst_awready", awready, 0);
            check("rst_wready", wready, 0);
            check("rst_arready", arready, 0);
            check("rst_bvalid", bvalid, 0);
            check("rst_rvalid", rvalid, 0);
            check("rst_bresp", bresp, 0);
            check("rst_rresp", rresp, 0);
            check("rst_rdata", rdata, 0);
            for (int i = 0; i < NR; i++) begin
                mem[i] = '0;
                check($sformatf("rst_reg%0d", i), regs_q[i*32 +: 32], 0);
            end
            alive = 0; have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
        end else begin
            exp_awr = alive && !have_aw && !b_pend;
            exp_wr  = alive && !have_w && !b_pend;
            exp_arr = alive && !r_pend;
            check("awready", awready, exp_awr);
            check("wready", wready, exp_wr);
            check("arready", arready, exp_arr);
            check("bvalid", bvalid, b_pend);
            check("rvalid", rvalid, r_pend);
            if (b_pend) check("bresp", bresp, m_b_resp);
            if (r_pend) begin
                check("rdata", rdata, m_r_data);
                check("rresp", rresp, m_r_resp);
            end
            for (int i = 0; i < NR; i++)
                check($sformatf("reg%0d", i), regs_q[i*32 +: 32], mem[i]);

            // what the coming rising edge does
            aw_h = awvalid && exp_awr;
            w_h  = wvalid && exp_wr;
            ar_h = arvalid && exp_arr;
            if (ar_h) begin
                r_pend = 1;
                if (m_err(araddr, arprot)) begin
                    m_r_data = 0; m_r_resp = 2'b10;
                end else begin
                    m_r_data = mem[(araddr / 4) % NR]; m_r_resp = 2'b00;
                end
            end else if (r_pend && rready) begin
                r_pend = 0;
            end
            if (b_pend && bready) b_pend = 0;
            if (aw_h) begin have_aw = 1; m_aw_addr = awaddr; m_aw_prot = awprot; end
            if (w_h)  begin have_w = 1; m_w_data = wdata; m_w_strb = wstrb; end
            if (have_aw && have_w) begin
                have_aw = 0; have_w = 0; b_pend = 1;
                if (m_err(m_aw_addr, m_aw_prot)) begin
                    m_b_resp = 2'b10;
                end else begin
                    m_b_resp = 2'b00;
                    idx = (m_aw_addr / 4) % NR;
                    for (int b = 0; b < 4; b++)
                        if (m_w_strb[b]) mem[idx][b*8 +: 8] = m_w_data[b*8 +: 8];
                end
            end
            alive = 1;
        end
    end

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot,
                             input int w_lead, input int b_delay,
                             output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, aw_h, w_h, got = 0;
        int cyc = 0;
        resp = 2'bxx; lat = 0;
        awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
        wvalid = 1;
        if (w_lead == 0) awvalid = 1;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge aclk);
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_h) begin aw_done = 1; awvalid = 0; end
            if (w_h)  begin w_done = 1; wvalid = 0; end
            cyc++;
            if (!aw_done && cyc >= w_lead) awvalid = 1;
        end
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            awvalid = 0; wvalid = 0;
            return;
        end
        bready = (b_delay == 0);
        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge aclk);
            cyc++;
            if (bvalid && lat == 0) lat = cyc;
            if (bvalid && bready) begin resp = bresp; got = 1; end
            @(posedge aclk); #1;
            if (cyc >= b_delay) bready = 1;
        end
        bready = 0;
        if (!got) check("b_timeout", 0, 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot,
                            output logic [31:0] data, output logic [1:0] resp);
        bit done = 0, h, got = 0;
        int cyc = 0;
        data = 'x; resp = 2'bxx;
        araddr = addr; arprot = prot; arvalid = 1;
        while (!done && cyc < 40) begin
            @(negedge aclk);
            h = arvalid && arready;
            @(posedge aclk); #1;
            cyc++;
            if (h) begin done = 1; arvalid = 0; end
        end
        if (!done) begin
            check("ar_timeout", 0, 1);
            arvalid = 0;
            return;
        end
        rready = 1;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge aclk);
            cyc++;
            if (rvalid) begin data = rdata; resp = rresp; got = 1; end
            @(posedge aclk); #1;
        end
        rready = 0;
        if (!got) check("r_timeout", 0, 1);
        else check("r_latency", cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [1:0]  resp, resp2;
        logic [31:0] data;
        int          lat;

        repeat (3) @(posedge aclk);
        #1 aresetn = 1;
        @(negedge aclk);
        check("ready_before_first_edge", {awready, wready, arready}, 3'b000);
        @(posedge aclk); #1;
        check("ready_after_first_edge", {awready, wready, arready}, 3'b111);

        // AW and W together
        axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 0, resp, lat);
        $display("write 0x08 <= 0xdeadbeef strb f: bresp %b lat %0d", resp, lat);
        check("w08_bresp", resp, 2'b00);
        check("w08_bvalid_latency", lat, 1);
        axi_read(32'h08, 3'b001, data, resp);
        $display("read  0x08 => 0x%h rresp %b", data, resp);
        check("r08_data", data, 32'hDEAD_BEEF);
        check("r08_rresp", resp, 2'b00);

        // byte offset is ignored
        axi_read(32'h0B, 3'b001, data, resp);
        $display("read  0x0b => 0x%h rresp %b", data, resp);
        check("r0b_data", data, 32'hDEAD_BEEF);

        // W leading AW by three cycles, partial strobe
        axi_write(32'h04, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, 0, resp, lat);
        $display("write 0x04 <= 0xffffffff strb f: bresp %b", resp);
        axi_write(32'h04, 32'h1122_3344, 4'h5, 3'b001, 3, 0, resp, lat);
        $display("write 0x04 <= 0x11223344 strb 5 (W first): bresp %b", resp);
        check("w04_bresp", resp, 2'b00);
        axi_read(32'h04, 3'b001, data, resp);
        $display("read  0x04 => 0x%h rresp %b", data, resp);
        check("r04_data", data, 32'hFF22_FF44);

        // out of range
        axi_write(32'h40, 32'h5555_5555, 4'hF, 3'b001, 0, 0, resp, lat);
        $display("write 0x40 <= 0x55555555: bresp %b", resp);
        check("w40_bresp", resp, 2'b10);
        check("w40_reg0_untouched", regs_q[0 +: 32], 32'h0);
        check("w40_reg2_untouched", regs_q[64 +: 32], 32'hDEAD_BEEF);
        axi_read(32'h40, 3'b001, data, resp);
        $display("read  0x40 => 0x%h rresp %b", data, resp);
        check("r40_data", data, 32'h0);
        check("r40_rresp", resp, 2'b10);

        // bready held off while a read runs alongside
        fork
            begin
                axi_write(32'h10, 32'h0BAD_CAFE, 4'hF, 3'b001, 0, 5, resp, lat);
                $display("write 0x10 <= 0x0badcafe (bready late): bresp %b", resp);
            end
            begin
                axi_read(32'h08, 3'b001, data, resp2);
                $display("read  0x08 => 0x%h rresp %b (during pending B)", data, resp2);
                check("b_still_valid_during_read", bvalid, 1);
                check("awready_low_during_b", {awready, wready}, 2'b00);
            end
        join
        check("w10_bresp", resp, 2'b00);
        check("rconc_data", data, 32'hDEAD_BEEF);
        check("rconc_rresp", resp2, 2'b00);

        // read and write commit to the same register in the same cycle
        axi_write(32'h0C, 32'h1234_5678, 4'hF, 3'b001, 0, 0, resp, lat);
        $display("write 0x0c <= 0x12345678: bresp %b", resp);
        fork
            axi_write(32'h0C, 32'hCAFE_F00D, 4'hF, 3'b001, 0, 0, resp, lat);
            axi_read(32'h0C, 3'b001, data, resp2);
        join
        $display("read  0x0c => 0x%h alongside write 0xcafef00d", data);
        check("same_cycle_old_value", data, 32'h1234_5678);
        axi_read(32'h0C, 3'b001, data, resp);
        $display("read  0x0c => 0x%h rresp %b", data, resp);
        check("r0c_new_value", data, 32'hCAFE_F00D);

        // unprivileged vs privileged access
        axi_write(32'h14, 32'h7777_7777, 4'hF, 3'b000, 0, 0, resp, lat);
        $display("write 0x14 <= 0x77777777 prot 000: bresp %b", resp);
        check("w14_unpriv_bresp", resp, UNPRIV_RESP);
        check("w14_unpriv_reg5", regs_q[5*32 +: 32], UNPRIV_REG5);
        axi_write(32'h14, 32'h7777_7777, 4'hF, 3'b001, 0, 0, resp, lat);
        $display("write 0x14 <= 0x77777777 prot 001: bresp %b", resp);
        check("w14_priv_bresp", resp, 2'b00);
        axi_read(32'h14, 3'b000, data, resp);
        $display("read  0x14 prot 000 => 0x%h rresp %b", data, resp);
        check("r14_unpriv_data", data, UNPRIV_RD);
        check("r14_unpriv_rresp", resp, UNPRIV_RESP);

        // reset while only AW has been accepted
        awaddr = 32'h0C; awprot = 3'b001; wdata = 32'hFFFF_0000; wstrb = 4'hF; awvalid = 1;
        @(negedge aclk);
        check("aw_only_accepted", awready, 1);
        @(posedge aclk); #1;
        awvalid = 0;
        @(negedge aclk);
        check("have_aw_ready", {awready, wready}, 2'b01);
        @(posedge aclk); #1;
        aresetn = 0;
        #1;
        check("async_rst_outputs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("async_rst_reg3", regs_q[3*32 +: 32], 32'h0);
        $display("reset pulsed with AW held for 0x0c");
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;
        @(posedge aclk); #1;
        axi_read(32'h0C, 3'b001, data, resp);
        $display("read  0x0c after reset => 0x%h rresp %b", data, resp);
        check("r0c_after_reset", data, 32'h0);
        axi_write(32'h0C, 32'h600D_600D, 4'hF, 3'b001, 0, 0, resp, lat);
        $display("write 0x0c <= 0x600d600d after reset: bresp %b", resp);
        check("w0c_after_reset_bresp", resp, 2'b00);
        axi_read(32'h0C, 3'b001, data, resp);
        $display("read  0x0c => 0x%h rresp %b", data, resp);
        check("r0c_after_reset_write", data, 32'h600D_600D);

        repeat (2) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4lite_reg_slave.md
AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, meaning register count (power of two, 2..256).
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 SHALL have these clock and reset ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
REQ-006 SHALL have these write-channel ports:
- awaddr in ADDR_WIDTH; awprot in 3; awvalid in 1; awready out 1
- wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wvalid in 1; wready out 1
- bresp out 2; bvalid out 1; bready in 1
REQ-007 SHALL have these read-channel ports:
- araddr in ADDR_WIDTH; arprot in 3; arvalid in 1; arready out 1
- rdata out DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1
REQ-008 SHALL have port regs_q, output, NUM_REGS*DATA_WIDTH, meaning flattened register contents; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-009 SHALL decode the register index as addr bits [log2(DATA_WIDTH/8) +: log2(NUM_REGS)]; SHALL ignore the byte-offset bits below that field.
REQ-010 SHALL treat any nonzero address bit above the index field as out of range.
REQ-011 SHALL accept AW and W independently; SHALL assert awready when no AW is held and no B response is pending, and wready when no W is held and no B response is pending.
REQ-012 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
- W_IDLE to W_HAVE_AW on an AW handshake only.
- W_IDLE to W_HAVE_W on a W handshake only.
- W_IDLE to W_RESP on both handshakes in the same cycle.
- W_HAVE_AW and W_HAVE_W to W_RESP on the missing handshake.
- W_RESP to W_IDLE when bvalid && bready.
REQ-013 SHALL commit the write on entry to W_RESP, updating only the byte lanes whose wstrb bit is 1; an out-of-range write SHALL modify no register.
REQ-014 SHALL assert bvalid in the cycle after the write completes; bresp SHALL be 2'b00 (OKAY), or 2'b10 (SLVERR) when out of range; bvalid and bresp SHALL hold until bready.
REQ-015 SHALL assert arready whenever rvalid is 0.
REQ-016 On an AR handshake, SHALL assert rvalid in the next cycle with rdata set to the register value sampled in the handshake cycle.
REQ-017 An out-of-range read SHALL return rdata 0 and rresp 2'b10; otherwise rresp SHALL be 2'b00.
REQ-018 SHALL hold rvalid, rdata and rresp stable until rready; SHALL clear rvalid in the cycle after rvalid && rready.
REQ-019 A same-cycle AR handshake and write commit to the same register SHALL return the pre-write value.
REQ-020 Read and write channels SHALL be fully independent; neither SHALL stall the other.
REQ-021 SHALL allow at most one outstanding transaction per direction.

Reset
REQ-022 While aresetn is 0, SHALL drive awready, wready, bvalid, arready and rvalid to 0; bresp, rresp and rdata to 0; all registers to 0; write FSM to W_IDLE.
REQ-023 SHALL abandon any in-flight transaction at reset without committing it.
REQ-024 SHALL raise awready, wready and arready in the first aclk edge after aresetn deasserts.

Configuration
REQ-025 SHALL support macro AXIL_PROT_CHECK_EN.
- Defined: a write with awprot[0]=0 (unprivileged) SHALL complete with bresp SLVERR and modify no register; a read with arprot[0]=0 SHALL return rdata 0 with rresp SLVERR.
- Undefined: awprot and arprot SHALL be ignored.

Verification
REQ-026 SHALL cover: AW and W in the same cycle, addr 0x08, data 0xDEADBEEF, wstrb 0xF -> bvalid one cycle later, bresp 00; a following read of 0x08 returns 0xDEADBEEF, rresp 00.
REQ-027 SHALL cover: W three cycles before AW, addr 0x04, data 0x11223344, wstrb 0x5 with register previously 0xFFFFFFFF -> register reads 0xFF22FF44.
REQ-028 SHALL cover: write to 0x40 with NUM_REGS=16 -> bresp 10, all registers unchanged; read of 0x40 -> rdata 0, rresp 10.
REQ-029 SHALL cover: bready held low 5 cycles -> bvalid and bresp stable, awready and wready low; a concurrent read still completes.
REQ-030 SHALL cover: aresetn pulsed low while in W_HAVE_AW -> all outputs 0 during reset; a subsequent read of that register returns 0.
REQ-031 SHALL cover, with AXIL_PROT_CHECK_EN: write with awprot=3'b000 -> bresp 10, register unchanged; the same write with awprot=3'b001 -> bresp 00.
